// File: rtl/dm_pkg.sv
// Shared definitions for the dm_pipe data-memory pipeline: op codes, FSM states, limits.
package dm_pkg;

    localparam logic [2:0] OpWord  = 3'b000;
    localparam logic [2:0] OpHalf  = 3'b001;
    localparam logic [2:0] OpByte  = 3'b010;
    localparam logic [2:0] OpHalfU = 3'b101;
    localparam logic [2:0] OpByteU = 3'b110;

    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned CntW        = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/dm_align.sv
// Combinational lane steering: byte enables, store-data placement, error flag and load extension.
module dm_align
    import dm_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = '0;
        err_o   = 1'b0;
        rdata_o = '0;
        // Store data is moved up to the addressed lane; load data is moved down to lane 0.
        wword_o = wdata_i << {addr_lo_i, 3'b000};
        shifted = rword_i >> {addr_lo_i, 3'b000};
        unique case (op_i)
            OpWord: begin
                if (addr_lo_i != 2'b00) begin
                    err_o = 1'b1;
                end else begin
                    be_o    = 4'b1111;
                    rdata_o = rword_i;
                end
            end
            OpHalf, OpHalfU: begin
                if (addr_lo_i[0]) begin
                    err_o = 1'b1;
                end else begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    rdata_o = {{16{(op_i == OpHalf) & shifted[15]}}, shifted[15:0]};
                end
            end
            OpByte, OpByteU: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {{24{(op_i == OpByte) & shifted[7]}}, shifted[7:0]};
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_pipe.sv
// Single-outstanding data memory with a fixed request-to-response latency and
// valid/ready handshakes on both request and response sides.
module dm_pipe
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [7:0]      mem_q [Depth];
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [ADDR_W-3:0] word_addr;
    logic [31:0]       rword;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic              acc_err;
    logic [31:0]       ld_data;
    logic              accept;

    assign word_addr = req_addr[ADDR_W-1:2];
    assign rword     = {mem_q[{word_addr, 2'd3}], mem_q[{word_addr, 2'd2}],
                        mem_q[{word_addr, 2'd1}], mem_q[{word_addr, 2'd0}]};

    dm_align u_align (
        .op_i      (req_op),
        .addr_lo_i (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .rword_i   (rword),
        .be_o      (be),
        .wword_o   (wword),
        .err_o     (acc_err),
        .rdata_o   (ld_data)
    );

    assign req_ready  = (state_q == StIdle);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Memory is deliberately outside the reset domain so committed stores survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[{word_addr, 2'(i)}] <= wword[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rdata_d = (req_we || acc_err) ? 32'h0 : ld_data;
                    err_d   = acc_err;
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = CntW'(LATENCY - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: a LATENCY=1 instance driven from a vector table and a
// LATENCY=3 instance exercising back-pressure and reset during WAIT.
module tb_dm_pipe;

    logic        clk;
    logic        rstn1, rstn3;
    logic        req_valid1, req_valid3;
    logic        resp_ready1, resp_ready3;
    logic [2:0]  req_op;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;

    logic        req_ready1, req_ready3;
    logic        resp_valid1, resp_valid3;
    logic [31:0] resp_rdata1, resp_rdata3;
    logic        resp_err1, resp_err3;

    int checks   = 0;
    int failures = 0;

    logic        sel3;
    logic        rr_m, rv_m, re_m;
    logic [31:0] rd_m;

    dm_pipe #(.ADDR_W(9), .LATENCY(1)) dut1 (
        .clk        (clk),
        .rstn       (rstn1),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_op     (req_op),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_rdata (resp_rdata1),
        .resp_err   (resp_err1)
    );

    dm_pipe #(.ADDR_W(9), .LATENCY(3)) dut3 (
        .clk        (clk),
        .rstn       (rstn3),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_op     (req_op),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid3),
        .resp_ready (resp_ready3),
        .resp_rdata (resp_rdata3),
        .resp_err   (resp_err3)
    );

    always_comb begin
        rr_m = sel3 ? req_ready3  : req_ready1;
        rv_m = sel3 ? resp_valid3 : resp_valid1;
        rd_m = sel3 ? resp_rdata3 : resp_rdata1;
        re_m = sel3 ? resp_err3   : resp_err1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NVec = 26;
    vec_t vecs [NVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction with resp_ready held high; checks the latency profile too.
    task automatic xact(input logic d3, input logic we, input logic [2:0] op,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string name);
        int lat;
        lat = d3 ? 3 : 1;
        @(negedge clk);
        sel3        = d3;
        req_we      = we;
        req_op      = op;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid1  = !d3;
        req_valid3  = d3;
        resp_ready1 = 1'b1;
        resp_ready3 = 1'b1;
        #1;
        chk({name, ".req_ready"}, 32'(rr_m), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk($sformatf("%s.wait%0d", name, i), 32'(rv_m), 32'd0);
            @(negedge clk);
        end
        chk({name, ".resp_valid"}, 32'(rv_m), 32'd1);
        chk({name, ".rdata"}, rd_m, exp_rdata);
        chk({name, ".err"}, 32'(re_m), 32'(exp_err));
        @(negedge clk);
        chk({name, ".resp_done"}, 32'(rv_m), 32'd0);
        chk({name, ".ready_back"}, 32'(rr_m), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'b000, 9'h010, 32'h12345678, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 9'h010, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b0, 3'b010, 9'h013, 32'h0,        32'h00000012, 1'b0};
        vecs[3]  = '{1'b1, 3'b010, 9'h011, 32'h00000080, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 9'h010, 32'h0,        32'hFFFF8078, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 9'h010, 32'h0,        32'h00008078, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 9'h012, 32'h0,        32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 3'b001, 9'h011, 32'h0000BEEF, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 3'b000, 9'h010, 32'h0,        32'h12348078, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 9'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 3'b100, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 3'b111, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 3'b000, 9'h010, 32'h0,        32'h12348078, 1'b0};
        vecs[13] = '{1'b0, 3'b110, 9'h011, 32'h0,        32'h00000080, 1'b0};
        vecs[14] = '{1'b0, 3'b010, 9'h011, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[15] = '{1'b1, 3'b000, 9'h01C, 32'h11223344, 32'h00000000, 1'b0};
        vecs[16] = '{1'b1, 3'b101, 9'h01E, 32'hA5A5C3D2, 32'h00000000, 1'b0};
        vecs[17] = '{1'b1, 3'b110, 9'h01C, 32'h000000EE, 32'h00000000, 1'b0};
        vecs[18] = '{1'b0, 3'b000, 9'h01C, 32'h0,        32'hC3D233EE, 1'b0};
        vecs[19] = '{1'b0, 3'b001, 9'h01E, 32'h0,        32'hFFFFC3D2, 1'b0};
        vecs[20] = '{1'b1, 3'b000, 9'h1FC, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[21] = '{1'b0, 3'b110, 9'h1FF, 32'h0,        32'h000000DE, 1'b0};
        vecs[22] = '{1'b0, 3'b101, 9'h1FE, 32'h0,        32'h0000DEAD, 1'b0};
        vecs[23] = '{1'b0, 3'b000, 9'h1FC, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[24] = '{1'b1, 3'b000, 9'h012, 32'h0BADF00D, 32'h00000000, 1'b1};
        vecs[25] = '{1'b0, 3'b000, 9'h010, 32'h0,        32'h12348078, 1'b0};

        sel3        = 1'b0;
        rstn1       = 1'b0;
        rstn3       = 1'b0;
        req_valid1  = 1'b0;
        req_valid3  = 1'b0;
        resp_ready1 = 1'b0;
        resp_ready3 = 1'b0;
        req_op      = 3'b000;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;

        repeat (3) @(negedge clk);
        chk("rst.resp_valid1", 32'(resp_valid1), 32'd0);
        chk("rst.resp_rdata1", resp_rdata1, 32'd0);
        chk("rst.resp_err1", 32'(resp_err1), 32'd0);
        chk("rst.resp_valid3", 32'(resp_valid3), 32'd0);
        rstn1 = 1'b1;
        rstn3 = 1'b1;
        @(negedge clk);
        chk("rst.req_ready1", 32'(req_ready1), 32'd1);
        chk("rst.req_ready3", 32'(req_ready3), 32'd1);
        chk("rst.resp_valid1_post", 32'(resp_valid1), 32'd0);
        chk("rst.resp_err3_post", 32'(resp_err3), 32'd0);

        for (int v = 0; v < NVec; v++) begin
            xact(1'b0, vecs[v].we, vecs[v].op, vecs[v].addr, vecs[v].wdata,
                 vecs[v].rdata, vecs[v].err, $sformatf("vec%0d", v));
        end

        // LATENCY=3 with response back-pressure.
        xact(1'b1, 1'b1, 3'b000, 9'h040, 32'h55AA33CC, 32'h0, 1'b0, "l3.store");
        @(negedge clk);
        sel3        = 1'b1;
        req_we      = 1'b0;
        req_op      = 3'b000;
        req_addr    = 9'h040;
        req_valid3  = 1'b1;
        resp_ready3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        chk("l3.hold.wait1", 32'(resp_valid3), 32'd0);
        chk("l3.hold.busy1", 32'(req_ready3), 32'd0);
        @(negedge clk);
        chk("l3.hold.wait2", 32'(resp_valid3), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("l3.hold.valid%0d", k), 32'(resp_valid3), 32'd1);
            chk($sformatf("l3.hold.rdata%0d", k), resp_rdata3, 32'h55AA33CC);
            chk($sformatf("l3.hold.ready%0d", k), 32'(req_ready3), 32'd0);
            @(negedge clk);
        end
        chk("l3.hold.still_valid", 32'(resp_valid3), 32'd1);
        resp_ready3 = 1'b1;
        @(negedge clk);
        chk("l3.hold.released", 32'(resp_valid3), 32'd0);
        chk("l3.hold.idle", 32'(req_ready3), 32'd1);

        // Reset while the store response is still in WAIT.
        req_we     = 1'b1;
        req_op     = 3'b000;
        req_addr   = 9'h020;
        req_wdata  = 32'hCAFEBABE;
        req_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        chk("rw.in_wait", 32'(resp_valid3), 32'd0);
        rstn3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rw.rst_valid%0d", k), 32'(resp_valid3), 32'd0);
        end
        rstn3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rw.post_valid%0d", k), 32'(resp_valid3), 32'd0);
            chk($sformatf("rw.post_ready%0d", k), 32'(req_ready3), 32'd1);
        end
        xact(1'b1, 1'b0, 3'b000, 9'h020, 32'h0, 32'hCAFEBABE, 1'b0, "rw.load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
